// File: rtl/wb_writeback_pkg.sv
// Shared writeback encodings: writeback-source select codes, load-type codes,
// the register-zero constant and the W-stage control bundle.
package wb_writeback_pkg;

    localparam logic [1:0] WB_SEL_ALU = 2'd0;
    localparam logic [1:0] WB_SEL_MEM = 2'd1;
    localparam logic [1:0] WB_SEL_PC8 = 2'd2;

    localparam logic [2:0] LD_LW  = 3'd0;
    localparam logic [2:0] LD_LB  = 3'd1;
    localparam logic [2:0] LD_LBU = 3'd2;
    localparam logic [2:0] LD_LH  = 3'd3;
    localparam logic [2:0] LD_LHU = 3'd4;

    localparam logic [4:0] REG_ZERO = 5'd0;

    typedef struct packed {
        logic       valid;
        logic       regWrite;
        logic [1:0] wbSel;
        logic [2:0] loadType;
        logic [1:0] byteOff;
    } wCtrl_t;

endpackage

// File: rtl/wb_writeback_load_ext.sv
// Combinational load extractor: picks byte/halfword from a raw data-memory word
// and sign- or zero-extends it; unknown load types pass the word through.
module load_ext
    import wb_writeback_pkg::*;
#(
    parameter int DW = 32
) (
    input  logic [2:0]    loadType,
    input  logic [1:0]    byteOff,
    input  logic [DW-1:0] rdata,
    output logic [DW-1:0] data
);

    logic signed [7:0]    byteSel;
    logic signed [15:0]   halfSel;
    logic signed [DW-1:0] byteSx;
    logic signed [DW-1:0] halfSx;

    always_comb begin
        byteSel = rdata[{byteOff, 3'b000} +: 8];
        halfSel = rdata[{byteOff[1], 4'b0000} +: 16];
        byteSx  = byteSel;
        halfSx  = halfSel;
        case (loadType)
            LD_LB:   data = byteSx;
            LD_LBU:  data = {{(DW-8){1'b0}}, byteSel};
            LD_LH:   data = halfSx;
            LD_LHU:  data = {{(DW-16){1'b0}}, halfSel};
            default: data = rdata;
        endcase
    end

endmodule

// File: rtl/wb_writeback.sv
// Register-file writer: M->W pipeline register, load extension, source select,
// and a 1-entry MDU result buffer that yields to the pipeline. Optional: WB_TRACE_EN.
module wb_writeback
    import wb_writeback_pkg::*;
#(
    parameter int DW = 32,
    parameter int AW = 5
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          stall_w,
    input  logic          flush_w,
    input  logic          m_valid,
    input  logic [31:0]   m_pc,
    input  logic          m_reg_write,
    input  logic [AW-1:0] m_reg_addr,
    input  logic [1:0]    m_wb_sel,
    input  logic [2:0]    m_load_type,
    input  logic [1:0]    m_byte_off,
    input  logic [DW-1:0] m_alu_result,
    input  logic [DW-1:0] m_mem_rdata,
    input  logic          mdu_valid,
    input  logic [AW-1:0] mdu_addr,
    input  logic [DW-1:0] mdu_data,
    output logic          mdu_ready,
    output logic          mdu_pending,
    output logic          RegWrite,
    output logic [AW-1:0] RegAddr,
    output logic [DW-1:0] RegData,
    output logic [31:0]   w_pc
);

    wCtrl_t        wCtrl_p1;
    logic [31:0]   wPc_p1;
    logic [AW-1:0] wAddr_p1;
    logic [DW-1:0] wAlu_p1;
    logic [DW-1:0] wMem_p1;

    logic          bufFull;
    logic [AW-1:0] bufAddr;
    logic [DW-1:0] bufData;

    logic          pipeWe;
    logic          mduAccept;
    logic [DW-1:0] ldData;
    logic [DW-1:0] pipeData;

    // M -> W boundary
    always_ff @(posedge clk) begin
        if (reset || flush_w) begin
            wCtrl_p1 <= '0;
            wPc_p1   <= '0;
            wAddr_p1 <= '0;
            wAlu_p1  <= '0;
            wMem_p1  <= '0;
        end else if (!stall_w) begin
            wCtrl_p1 <= '{valid: m_valid, regWrite: m_reg_write, wbSel: m_wb_sel,
                          loadType: m_load_type, byteOff: m_byte_off};
            wPc_p1   <= m_pc;
            wAddr_p1 <= m_reg_addr;
            wAlu_p1  <= m_alu_result;
            wMem_p1  <= m_mem_rdata;
        end
    end

    load_ext #(.DW(DW)) uLoadExt (
        .loadType (wCtrl_p1.loadType),
        .byteOff  (wCtrl_p1.byteOff),
        .rdata    (wMem_p1),
        .data     (ldData)
    );

    always_comb begin
        pipeWe = wCtrl_p1.valid & wCtrl_p1.regWrite & (wAddr_p1 != AW'(REG_ZERO));
        case (wCtrl_p1.wbSel)
            WB_SEL_MEM: pipeData = ldData;
            WB_SEL_PC8: pipeData = DW'(wPc_p1 + 32'd8);
            default:    pipeData = wAlu_p1;
        endcase
    end

    assign mdu_ready   = !bufFull;
    assign mdu_pending = bufFull;
    assign mduAccept   = mdu_valid & !bufFull;

    // MDU buffer: a zero-destination offer is consumed but never held
    always_ff @(posedge clk) begin
        if (reset) begin
            bufFull <= 1'b0;
        end else if (mduAccept) begin
            bufFull <= (mdu_addr != AW'(REG_ZERO));
        end else if (bufFull && !pipeWe) begin
            bufFull <= 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (mduAccept) begin
            bufAddr <= mdu_addr;
            bufData <= mdu_data;
        end
    end

    always_comb begin
        RegWrite = 1'b0;
        RegAddr  = '0;
        RegData  = '0;
        if (pipeWe) begin
            RegWrite = 1'b1;
            RegAddr  = wAddr_p1;
            RegData  = pipeData;
        end else if (bufFull) begin
            RegWrite = 1'b1;
            RegAddr  = bufAddr;
            RegData  = bufData;
        end
    end

    assign w_pc = wPc_p1;

`ifdef WB_TRACE_EN
    always_ff @(posedge clk) begin
        if (!reset && RegWrite) begin
            if (pipeWe) $display("@%h: $%d <= %h", w_pc, RegAddr, RegData);
            else        $display("@mdu: $%d <= %h", RegAddr, RegData);
        end
    end
`endif

endmodule

// File: tb/tb_wb_writeback.sv
// Directed bench for wb_writeback: vector table for load/select paths plus
// hand sequences for MDU arbitration, stall/flush and mid-operation reset.
module tb_wb_writeback;

    logic        clk = 1'b0;
    logic        reset;
    logic        stall_w, flush_w;
    logic        m_valid;
    logic [31:0] m_pc;
    logic        m_reg_write;
    logic [4:0]  m_reg_addr;
    logic [1:0]  m_wb_sel;
    logic [2:0]  m_load_type;
    logic [1:0]  m_byte_off;
    logic [31:0] m_alu_result, m_mem_rdata;
    logic        mdu_valid;
    logic [4:0]  mdu_addr;
    logic [31:0] mdu_data;
    logic        mdu_ready, mdu_pending, RegWrite;
    logic [4:0]  RegAddr;
    logic [31:0] RegData, w_pc;

    int tests = 0;
    int fails = 0;

    wb_writeback #(.DW(32), .AW(5)) dut (
        .clk(clk), .reset(reset), .stall_w(stall_w), .flush_w(flush_w),
        .m_valid(m_valid), .m_pc(m_pc), .m_reg_write(m_reg_write),
        .m_reg_addr(m_reg_addr), .m_wb_sel(m_wb_sel), .m_load_type(m_load_type),
        .m_byte_off(m_byte_off), .m_alu_result(m_alu_result), .m_mem_rdata(m_mem_rdata),
        .mdu_valid(mdu_valid), .mdu_addr(mdu_addr), .mdu_data(mdu_data),
        .mdu_ready(mdu_ready), .mdu_pending(mdu_pending), .RegWrite(RegWrite),
        .RegAddr(RegAddr), .RegData(RegData), .w_pc(w_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        valid;
        logic [31:0] pc;
        logic        rw;
        logic [4:0]  addr;
        logic [1:0]  sel;
        logic [2:0]  lt;
        logic [1:0]  off;
        logic [31:0] alu;
        logic [31:0] rdata;
        logic        expWe;
        logic [4:0]  expAddr;
        logic [31:0] expData;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic setM(input logic v, input logic [31:0] pc, input logic rw, input logic [4:0] a,
                        input logic [1:0] sel, input logic [2:0] lt, input logic [1:0] off,
                        input logic [31:0] alu, input logic [31:0] rd);
        m_valid = v; m_pc = pc; m_reg_write = rw; m_reg_addr = a; m_wb_sel = sel;
        m_load_type = lt; m_byte_off = off; m_alu_result = alu; m_mem_rdata = rd;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chkOut(input string tag, input logic we, input logic [4:0] a, input logic [31:0] d);
        chk({tag, " RegWrite"}, 32'(RegWrite), 32'(we));
        chk({tag, " RegAddr"}, 32'(RegAddr), 32'(a));
        chk({tag, " RegData"}, RegData, d);
    endtask

    initial begin
        //               valid pc            rw addr sel   lt    off   alu           rdata         we addr  data
        vecs[0]  = '{1'b1, 32'h0000_1000, 1'b1, 5'd8,  2'd1, 3'd1, 2'd3, 32'h0,        32'h80FF_1234, 1'b1, 5'd8,  32'hFFFF_FF80};
        vecs[1]  = '{1'b1, 32'h0000_1004, 1'b1, 5'd8,  2'd1, 3'd2, 2'd3, 32'h0,        32'h80FF_1234, 1'b1, 5'd8,  32'h0000_0080};
        vecs[2]  = '{1'b1, 32'h0000_3000, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0,        32'h0,         1'b1, 5'd31, 32'h0000_3008};
        vecs[3]  = '{1'b1, 32'h0000_100C, 1'b1, 5'd0,  2'd0, 3'd0, 2'd0, 32'h1111_2222, 32'h0,        1'b0, 5'd0,  32'h0};
        vecs[4]  = '{1'b1, 32'h0000_1010, 1'b1, 5'd9,  2'd1, 3'd3, 2'd3, 32'h0,        32'h80FF_1234, 1'b1, 5'd9,  32'hFFFF_80FF};
        vecs[5]  = '{1'b1, 32'h0000_1014, 1'b1, 5'd10, 2'd1, 3'd4, 2'd0, 32'h0,        32'h80FF_1234, 1'b1, 5'd10, 32'h0000_1234};
        vecs[6]  = '{1'b1, 32'h0000_1018, 1'b1, 5'd11, 2'd1, 3'd7, 2'd2, 32'h0,        32'h80FF_1234, 1'b1, 5'd11, 32'h80FF_1234};
        vecs[7]  = '{1'b1, 32'h0000_101C, 1'b1, 5'd12, 2'd3, 3'd1, 2'd0, 32'hCAFE_F00D, 32'h80FF_1234, 1'b1, 5'd12, 32'hCAFE_F00D};
        vecs[8]  = '{1'b0, 32'h0000_1020, 1'b1, 5'd13, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0,        1'b0, 5'd0,  32'h0};
        vecs[9]  = '{1'b1, 32'h0000_1024, 1'b0, 5'd14, 2'd0, 3'd0, 2'd0, 32'h1234_5678, 32'h0,        1'b0, 5'd0,  32'h0};
        vecs[10] = '{1'b1, 32'h0000_1028, 1'b1, 5'd15, 2'd1, 3'd1, 2'd1, 32'h0,        32'h80FF_1234, 1'b1, 5'd15, 32'h0000_0012};
        vecs[11] = '{1'b1, 32'hFFFF_FFFC, 1'b1, 5'd31, 2'd2, 3'd0, 2'd0, 32'h0,        32'h0,         1'b1, 5'd31, 32'h0000_0004};

        reset = 1'b1; stall_w = 1'b0; flush_w = 1'b0;
        mdu_valid = 1'b0; mdu_addr = 5'd0; mdu_data = 32'h0;
        setM(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        tick();
        tick();
        chkOut("reset", 1'b0, 5'd0, 32'h0);
        chk("reset w_pc", w_pc, 32'h0);
        chk("reset mdu_ready", 32'(mdu_ready), 32'd1);
        chk("reset mdu_pending", 32'(mdu_pending), 32'd0);
        reset = 1'b0;

        for (int i = 0; i < 12; i++) begin
            setM(vecs[i].valid, vecs[i].pc, vecs[i].rw, vecs[i].addr, vecs[i].sel,
                 vecs[i].lt, vecs[i].off, vecs[i].alu, vecs[i].rdata);
            tick();
            chkOut($sformatf("v%0d", i), vecs[i].expWe, vecs[i].expAddr, vecs[i].expData);
            chk($sformatf("v%0d w_pc", i), w_pc, vecs[i].pc);
        end

        // MDU offer to $0 with the pipeline idle: consumed, never written
        setM(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        tick();
        mdu_valid = 1'b1; mdu_addr = 5'd0; mdu_data = 32'h0000_1234;
        #1;
        chk("zero offer ready", 32'(mdu_ready), 32'd1);
        tick();
        mdu_valid = 1'b0;
        chk("zero offer pending", 32'(mdu_pending), 32'd0);
        chk("zero offer RegWrite", 32'(RegWrite), 32'd0);
        tick();
        chk("zero offer RegWrite later", 32'(RegWrite), 32'd0);

        // MDU offer while the pipeline writes three cycles in a row
        setM(1'b1, 32'h0000_2000, 1'b1, 5'd10, 2'd0, 3'd0, 2'd0, 32'hA0, 32'h0);
        mdu_valid = 1'b1; mdu_addr = 5'd5; mdu_data = 32'h0000_DEAD;
        tick();
        mdu_valid = 1'b0;
        for (int c = 0; c < 3; c++) begin
            chkOut($sformatf("starve c%0d", c), 1'b1, 5'(10 + c), 32'(32'hA0 + c));
            chk($sformatf("starve c%0d pending", c), 32'(mdu_pending), 32'd1);
            chk($sformatf("starve c%0d ready", c), 32'(mdu_ready), 32'd0);
            if (c < 2) setM(1'b1, 32'h0000_2004 + 32'(4 * c), 1'b1, 5'(11 + c), 2'd0, 3'd0, 2'd0,
                            32'(32'hA1 + c), 32'h0);
            else setM(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0);
            tick();
        end
        chkOut("drain", 1'b1, 5'd5, 32'h0000_DEAD);
        tick();
        chk("after drain ready", 32'(mdu_ready), 32'd1);
        chk("after drain pending", 32'(mdu_pending), 32'd0);
        chk("after drain RegWrite", 32'(RegWrite), 32'd0);

        // stall and flush together: flush wins
        setM(1'b1, 32'h0000_0300, 1'b1, 5'd7, 2'd0, 3'd0, 2'd0, 32'h77, 32'h0);
        tick();
        chkOut("pre-flush", 1'b1, 5'd7, 32'h77);
        setM(1'b1, 32'h0000_0304, 1'b1, 5'd9, 2'd0, 3'd0, 2'd0, 32'h99, 32'h0);
        stall_w = 1'b1; flush_w = 1'b1;
        tick();
        chkOut("stall+flush", 1'b0, 5'd0, 32'h0);
        chk("stall+flush w_pc", w_pc, 32'h0);
        stall_w = 1'b0; flush_w = 1'b0;
        tick();
        chkOut("post-flush", 1'b1, 5'd9, 32'h99);
        setM(1'b1, 32'h0000_0308, 1'b1, 5'd3, 2'd0, 3'd0, 2'd0, 32'h33, 32'h0);
        stall_w = 1'b1;
        for (int c = 0; c < 2; c++) begin
            tick();
            chkOut($sformatf("stall c%0d", c), 1'b1, 5'd9, 32'h99);
            chk($sformatf("stall c%0d w_pc", c), w_pc, 32'h0000_0304);
        end
        stall_w = 1'b0;

        // reset with a full buffer and a valid W
        setM(1'b1, 32'h0000_0400, 1'b1, 5'd4, 2'd0, 3'd0, 2'd0, 32'h44, 32'h0);
        mdu_valid = 1'b1; mdu_addr = 5'd6; mdu_data = 32'h66;
        tick();
        mdu_valid = 1'b0;
        chk("pre-reset pending", 32'(mdu_pending), 32'd1);
        chkOut("pre-reset", 1'b1, 5'd4, 32'h44);
        reset = 1'b1;
        tick();
        chkOut("mid reset", 1'b0, 5'd0, 32'h0);
        chk("mid reset w_pc", w_pc, 32'h0);
        chk("mid reset ready", 32'(mdu_ready), 32'd1);
        chk("mid reset pending", 32'(mdu_pending), 32'd0);
        reset = 1'b0;
        setM(1'b0, 32'h0, 1'b0, 5'd0, 2'd0, 3'd0, 2'd0, 32'h0, 32'h0);
        tick();
        chkOut("lost buffer", 1'b0, 5'd0, 32'h0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
